// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_rd,
    input  logic [4:0]       ex_rd,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             mem_req,
    input  logic             dmem_ack,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             trap,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, TRAP = 2'b10} state_t;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);
    state_t state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic load_use, mem_busy, freeze, redirect;
    assign load_use = ex_mem_rd & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign mem_busy  = mem_req & ~dmem_ack & (state != TRAP);
    assign freeze    = mem_busy | (state == TRAP);
    assign redirect  = id_branch_taken | id_jump;
    assign trap      = state == TRAP;
    assign state_dbg = state;
    // Pipeline controls: freeze beats load-use beats redirect; all low while in reset
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        if (rst_n && !freeze) begin
            pc_en       = ~load_use;
            ifid_en     = ~load_use;
            ifid_flush  = ~load_use & redirect;
            idex_en     = 1'b1;
            idex_bubble = load_use;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
        end
    end
    // Memory-wait FSM next state; TRAP absorbs until reset
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            RUN: if (mem_busy) begin
                state_nx = MEM_WAIT;
                wait_nx  = WW'(1);
            end
            MEM_WAIT: if (dmem_ack) begin
                state_nx = RUN;
                wait_nx  = '0;
            end else if (wait_cnt == TO) begin
                state_nx = TRAP;
            end else begin
                wait_nx = wait_cnt + 1'b1;
            end
            default: state_nx = TRAP;
        endcase
    end
    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end
    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze | load_use) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
